// File: rtl/rasterizer_mem_arbiter_if.sv
// rtl/rasterizer_mem_arbiter_if.sv - Avalon-MM style command/response bundle shared by requesters and the memory master
interface rasterizer_mem_arbiter_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/rasterizer_mem_arbiter.sv
// rtl/rasterizer_mem_arbiter.sv - two-requester SDRAM arbiter with in-order read ID FIFO; optional ARB_HOLD_LIMIT_EN preemption
module rasterizer_mem_arbiter #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 32,
    parameter int MAX_OUTST  = 16,
    parameter int HOLD_LIMIT = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    rasterizer_mem_arbiter_if.slave   s0,
    rasterizer_mem_arbiter_if.slave   s1,
    rasterizer_mem_arbiter_if.master  m,
    output logic [1:0]                grant,
    output logic                      err_orphan
);
    localparam int PTR_W = $clog2(MAX_OUTST);

    typedef enum logic [1:0] {ST_NONE, ST_G0, ST_G1} state_t;

    state_t              state, state_next;
    logic                rr;
    logic                req0, req1, preempt;
    logic [ADDR_W-1:0]   cmd_address;
    logic [DATA_W/8-1:0] cmd_byteenable;
    logic [DATA_W-1:0]   cmd_writedata;
    logic                sel_rd, sel_wr, cmd_read, cmd_write, cmd_wait;
    logic                id_mem [MAX_OUTST];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      fifo_cnt;
    logic                fifo_full, fifo_empty, push, pop, head;

    assign req0 = s0.read | s0.write;
    assign req1 = s1.read | s1.write;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CNT_W = $clog2(HOLD_LIMIT + 1);
    logic [CNT_W-1:0] hold_cnt;
    logic             at_limit, accept;

    assign at_limit = (hold_cnt == CNT_W'(HOLD_LIMIT));
    assign preempt  = at_limit & (((state == ST_G0) & req1) | ((state == ST_G1) & req0));
    assign accept   = (cmd_read | cmd_write) & ~m.waitrequest;

    // Count restarts whenever the owner changes; saturates while the other side is idle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                  hold_cnt <= '0;
        else if (state_next != state) hold_cnt <= '0;
        else if (accept && !at_limit) hold_cnt <= hold_cnt + 1'b1;
    end
`else
    localparam int unused_hold_limit = HOLD_LIMIT;
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_NONE;
            rr    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_NONE && state_next == ST_G0) rr <= 1'b1;
            if (state == ST_NONE && state_next == ST_G1) rr <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_NONE: begin
                if (req0 && (!req1 || !rr)) state_next = ST_G0;
                else if (req1)              state_next = ST_G1;
            end
            ST_G0:   if (!req0 || preempt) state_next = ST_NONE;
            ST_G1:   if (!req1 || preempt) state_next = ST_NONE;
            default: state_next = ST_NONE;
        endcase
    end

    // Write wins over a simultaneous read from the same requester
    always_comb begin
        cmd_address    = '0;
        cmd_byteenable = '0;
        cmd_writedata  = '0;
        sel_rd         = 1'b0;
        sel_wr         = 1'b0;
        case (state)
            ST_G0: begin
                cmd_address    = s0.address;
                cmd_byteenable = s0.byteenable;
                cmd_writedata  = s0.writedata;
                sel_wr         = s0.write & ~preempt;
                sel_rd         = s0.read & ~s0.write & ~preempt;
            end
            ST_G1: begin
                cmd_address    = s1.address;
                cmd_byteenable = s1.byteenable;
                cmd_writedata  = s1.writedata;
                sel_wr         = s1.write & ~preempt;
                sel_rd         = s1.read & ~s1.write & ~preempt;
            end
            default: ;
        endcase
        cmd_read  = sel_rd & ~fifo_full;
        cmd_write = sel_wr;
        cmd_wait  = preempt | m.waitrequest | (sel_rd & fifo_full);
    end

    assign m.address    = cmd_address;
    assign m.byteenable = cmd_byteenable;
    assign m.writedata  = cmd_writedata;
    assign m.read       = cmd_read;
    assign m.write      = cmd_write;

    assign s0.waitrequest = (state == ST_G0) ? cmd_wait : 1'b1;
    assign s1.waitrequest = (state == ST_G1) ? cmd_wait : 1'b1;

    // full comes from the registered count, so a same-cycle pop cannot unblock a push
    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(MAX_OUTST));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = cmd_read & ~m.waitrequest;
    assign pop        = m.readdatavalid & ~fifo_empty;
    assign head       = id_mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) id_mem[wr_ptr] <= (state == ST_G1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
            if (m.readdatavalid && fifo_empty) err_orphan <= 1'b1;
        end
    end

    assign s0.readdata      = m.readdata;
    assign s1.readdata      = m.readdata;
    assign s0.readdatavalid = pop & ~head;
    assign s1.readdatavalid = pop & head;

    assign grant = {state == ST_G1, state == ST_G0};
endmodule

// File: tb/tb_rasterizer_mem_arbiter.sv
// tb/tb_rasterizer_mem_arbiter.sv - directed bench for rasterizer_mem_arbiter with a 2-cycle-latency memory model
module tb_rasterizer_mem_arbiter;
    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
`ifdef ARB_HOLD_LIMIT_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 32;
`endif

    logic clock = 1'b0;
    logic reset;
    logic [1:0] grant;
    logic err_orphan;

    always #5 clock = ~clock;

    rasterizer_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s0_if ();
    rasterizer_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s1_if ();
    rasterizer_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

    rasterizer_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(16), .HOLD_LIMIT(HOLD)
    ) dut (
        .clock(clock), .reset(reset), .s0(s0_if), .s1(s1_if), .m(m_if),
        .grant(grant), .err_orphan(err_orphan)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int wr_idx = 0;
    int rd_idx = 0;
    logic [25:0] pend_addr [64];
    int          pend_due  [64];
    logic        mem_hold;
    int          orph_req = 0;
    int          orph_done = 0;
    logic [31:0] rx0 [$];
    logic [31:0] rx1 [$];
    logic [25:0] wlog_addr [$];
    logic [31:0] wlog_data [$];
    logic [3:0]  wlog_be [$];

    function automatic logic [31:0] data_of(input logic [25:0] a);
        return 32'hC0DE_0000 ^ {6'd0, a};
    endfunction

    // Memory side observer: records accepted commands and returned data at the falling edge
    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            wr_idx = 0;
            rx0.delete(); rx1.delete();
            wlog_addr.delete(); wlog_data.delete(); wlog_be.delete();
        end else begin
            if (m_if.read && !m_if.waitrequest) begin
                pend_addr[wr_idx % 64] = m_if.address;
                pend_due[wr_idx % 64]  = cyc + 2;
                wr_idx++;
            end
            if (m_if.write && !m_if.waitrequest) begin
                wlog_addr.push_back(m_if.address);
                wlog_data.push_back(m_if.writedata);
                wlog_be.push_back(m_if.byteenable);
            end
            if (s0_if.readdatavalid) rx0.push_back(s0_if.readdata);
            if (s1_if.readdatavalid) rx1.push_back(s1_if.readdata);
        end
    end

    initial begin
        m_if.readdatavalid = 1'b0;
        m_if.readdata      = '0;
        forever begin
            @(posedge clock); #2;
            m_if.readdatavalid = 1'b0;
            if (!reset) begin
                rd_idx = 0;
            end else if (orph_req != orph_done) begin
                orph_done++;
                m_if.readdatavalid = 1'b1;
                m_if.readdata      = 32'h0BAD_F00D;
            end else if (!mem_hold && rd_idx != wr_idx && pend_due[rd_idx % 64] <= cyc) begin
                m_if.readdatavalid = 1'b1;
                m_if.readdata      = data_of(pend_addr[rd_idx % 64]);
                rd_idx++;
            end
        end
    end

    task automatic clear_reqs();
        s0_if.read = 1'b0; s0_if.write = 1'b0; s0_if.address = '0;
        s0_if.byteenable = 4'hF; s0_if.writedata = '0;
        s1_if.read = 1'b0; s1_if.write = 1'b0; s1_if.address = '0;
        s1_if.byteenable = 4'hF; s1_if.writedata = '0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        clear_reqs();
        mem_hold = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic s0_reads(input int n, input logic [25:0] base, output int bad_grant);
        int acc = 0;
        int guard = 0;
        bad_grant = 0;
        s0_if.address = base;
        s0_if.read = 1'b1;
        while (acc < n && guard < 200) begin
            @(negedge clock);
            if (!s0_if.waitrequest) begin
                acc++;
                if (grant !== 2'b01) bad_grant++;
            end
            @(posedge clock); #1;
            s0_if.address = base + 26'(4 * acc);
            guard++;
        end
        s0_if.read = 1'b0;
        n_tests++; if (acc !== n) begin n_fail++; $display("FAIL s0_reads_done: got %0d required %0d", acc, n); end
    endtask

    task automatic wait_rx0(input int n);
        int guard = 0;
        while (rx0.size() < n && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        @(negedge clock);
        n_tests++; if (rx0.size() !== n) begin n_fail++; $display("FAIL rx0_count: got %0d required %0d", rx0.size(), n); end
    endtask

    task automatic test_reset();
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b required 00", grant); end
        n_tests++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err_orphan); end
        n_tests++; if ({m_if.read, m_if.write} !== 2'b00) begin n_fail++; $display("FAIL reset_mcmd: got %b required 00", {m_if.read, m_if.write}); end
        n_tests++; if (m_if.address !== 26'd0) begin n_fail++; $display("FAIL reset_maddr: got %h required 0", m_if.address); end
        n_tests++; if ({s0_if.waitrequest, s1_if.waitrequest} !== 2'b11) begin n_fail++; $display("FAIL reset_wait: got %b required 11", {s0_if.waitrequest, s1_if.waitrequest}); end
        n_tests++; if ({s0_if.readdatavalid, s1_if.readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rdv: got %b required 00", {s0_if.readdatavalid, s1_if.readdatavalid}); end
        do_reset();
    endtask

    task automatic test_read_stream();
        int bad;
        do_reset();
        s0_reads(15, 26'h100, bad);
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL t1_grant: got %0d bad cycles required 0", bad); end
        wait_rx0(15);
        for (int i = 0; i < 15 && i < rx0.size(); i++) begin
            n_tests++;
            if (rx0[i] !== data_of(26'h100 + 26'(4 * i))) begin
                n_fail++; $display("FAIL t1_data[%0d]: got %h required %h", i, rx0[i], data_of(26'h100 + 26'(4 * i)));
            end
        end
        n_tests++; if (rx1.size() !== 0) begin n_fail++; $display("FAIL t1_rx1: got %0d required 0", rx1.size()); end
    endtask

    task automatic test_contention();
        do_reset();
        s0_if.address = 26'h40; s0_if.read = 1'b1;
        s1_if.address = 26'h300; s1_if.writedata = 32'h1234_5678; s1_if.write = 1'b1;
        @(negedge clock);
        n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL t2_cycA: got %b required 00", grant); end
        @(posedge clock); #1;
        @(negedge clock);
        n_tests++; if ({grant, s0_if.waitrequest, s1_if.waitrequest} !== 4'b0101) begin n_fail++; $display("FAIL t2_cycB: got %b required 0101", {grant, s0_if.waitrequest, s1_if.waitrequest}); end
        @(posedge clock); #1 s0_if.read = 1'b0;
        @(negedge clock);
        n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL t2_cycC: got %b required 01", grant); end
        @(posedge clock); #1;
        @(negedge clock);
        n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL t2_idle: got %b required 00", grant); end
        @(posedge clock); #1;
        @(negedge clock);
        n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL t2_g1: got %b required 10", grant); end
        n_tests++; if ({m_if.write, m_if.address, m_if.writedata} !== {1'b1, 26'h300, 32'h1234_5678}) begin
            n_fail++; $display("FAIL t2_mwrite: got %b/%h/%h required 1/300/12345678", m_if.write, m_if.address, m_if.writedata);
        end
        @(posedge clock); #1 s1_if.write = 1'b0;
        wait_rx0(1);
    endtask

    task automatic test_fifo_full();
        int acc = 0;
        int guard = 0;
        int stall_bad = 0;
        do_reset();
        mem_hold = 1'b1;
        s0_if.address = 26'h400; s0_if.read = 1'b1;
        while (acc < 16 && guard < 100) begin
            @(negedge clock);
            if (!s0_if.waitrequest) acc++;
            @(posedge clock); #1;
            s0_if.address = 26'h400 + 26'(4 * acc);
            guard++;
        end
        n_tests++; if (acc !== 16) begin n_fail++; $display("FAIL t3_accepts: got %0d required 16", acc); end
        repeat (4) begin
            @(negedge clock);
            if (!(s0_if.waitrequest === 1'b1 && m_if.read === 1'b0)) stall_bad++;
            @(posedge clock); #1;
        end
        n_tests++; if (stall_bad !== 0) begin n_fail++; $display("FAIL t3_stall: got %0d unstalled cycles required 0", stall_bad); end
        mem_hold = 1'b0;
        @(negedge clock);
        n_tests++; if ({s0_if.readdatavalid, m_if.read, s0_if.waitrequest} !== 3'b101) begin
            n_fail++; $display("FAIL t3_pop_blocks_push: got %b required 101", {s0_if.readdatavalid, m_if.read, s0_if.waitrequest});
        end
        @(posedge clock); #1;
        @(negedge clock);
        n_tests++; if ({m_if.read, s0_if.waitrequest} !== 2'b10) begin n_fail++; $display("FAIL t3_resume: got %b required 10", {m_if.read, s0_if.waitrequest}); end
        @(posedge clock); #1 s0_if.read = 1'b0;
        wait_rx0(17);
    endtask

    task automatic test_switch_inflight();
        int bad;
        int guard = 0;
        do_reset();
        s0_reads(4, 26'h800, bad);
        s1_if.address = 26'h200; s1_if.writedata = 32'hDEAD_BEEF; s1_if.byteenable = 4'hF; s1_if.write = 1'b1;
        while (guard < 20) begin
            @(negedge clock);
            if (!s1_if.waitrequest) break;
            @(posedge clock); #1;
            guard++;
        end
        @(posedge clock); #1 s1_if.write = 1'b0;
        wait_rx0(4);
        for (int i = 0; i < 4 && i < rx0.size(); i++) begin
            n_tests++;
            if (rx0[i] !== data_of(26'h800 + 26'(4 * i))) begin
                n_fail++; $display("FAIL t4_data[%0d]: got %h required %h", i, rx0[i], data_of(26'h800 + 26'(4 * i)));
            end
        end
        n_tests++; if (rx1.size() !== 0) begin n_fail++; $display("FAIL t4_rx1: got %0d required 0", rx1.size()); end
        n_tests++; if (wlog_addr.size() !== 1) begin n_fail++; $display("FAIL t4_wcount: got %0d required 1", wlog_addr.size()); end
        else begin
            n_tests++; if ({wlog_addr[0], wlog_data[0], wlog_be[0]} !== {26'h200, 32'hDEAD_BEEF, 4'hF}) begin
                n_fail++; $display("FAIL t4_write: got %h/%h/%h required 200/deadbeef/f", wlog_addr[0], wlog_data[0], wlog_be[0]);
            end
        end
    endtask

    task automatic test_orphan();
        do_reset();
        @(posedge clock); #1 orph_req++;
        @(negedge clock);
        n_tests++; if ({m_if.readdatavalid, s0_if.readdatavalid, s1_if.readdatavalid} !== 3'b100) begin
            n_fail++; $display("FAIL t5_drop: got %b required 100", {m_if.readdatavalid, s0_if.readdatavalid, s1_if.readdatavalid});
        end
        @(posedge clock); #1;
        @(negedge clock);
        n_tests++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL t5_set: got %b required 1", err_orphan); end
        repeat (3) @(negedge clock);
        n_tests++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL t5_sticky: got %b required 1", err_orphan); end
        do_reset();
        @(negedge clock);
        n_tests++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL t5_clear: got %b required 0", err_orphan); end
    endtask

`ifdef ARB_HOLD_LIMIT_EN
    task automatic test_hold_limit();
        logic [1:0] exp_g [11];
        logic       exp_a [11];
        logic       acc;
        exp_g = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
        exp_a = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        s0_if.address = 26'hA00; s0_if.read = 1'b1;
        s1_if.address = 26'h500; s1_if.writedata = 32'h5555_AAAA; s1_if.write = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clock);
            acc = s0_if.read & ~s0_if.waitrequest;
            n_tests++; if (grant !== exp_g[c]) begin n_fail++; $display("FAIL t6_grant[%0d]: got %b required %b", c, grant, exp_g[c]); end
            n_tests++; if (acc !== exp_a[c]) begin n_fail++; $display("FAIL t6_accept[%0d]: got %b required %b", c, acc, exp_a[c]); end
            @(posedge clock); #1;
            if (acc) s0_if.address = s0_if.address + 26'd4;
            if (c == 7) s1_if.write = 1'b0;
            if (c == 10) s0_if.read = 1'b0;
        end
        wait_rx0(5);
    endtask
`endif

    initial begin
        reset = 1'b0;
        mem_hold = 1'b0;
        clear_reqs();
        m_if.waitrequest = 1'b0;
        test_reset();
        test_read_stream();
        test_contention();
        test_fifo_full();
        test_switch_inflight();
        test_orphan();
`ifdef ARB_HOLD_LIMIT_EN
        test_hold_limit();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
